axis_video_framer: RTL

// - Output stage directly downstream of Image_HazeRemoval M_AXIS: adds AXI4-Stream video framing for VDMA/display.
// - Counts pixels into column/row; drives TUSER (start of frame) and TLAST (end of line).
// - Checks upstream TLAST against the programmed frame size and flags short or long frames.
// - Buffers in a 2-entry skid buffer, so upstream is never stalled combinationally by downstream TREADY.

---
 rtl/haze_axis_pkg.sv | 23 ++
 rtl/axis_video_framer_if.sv | 28 ++
 rtl/axis_skid_buffer.sv | 64 ++++++
 rtl/axis_video_framer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/haze_axis_pkg.sv
// Shared definitions for the haze-removal AXI4-Stream output path.
package haze_axis_pkg;

  localparam int unsigned DATA_W = 32;

  // Pixel layout inside TDATA: R[23:16] G[15:8] B[7:0]
  localparam int unsigned RGB_W = 24;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;
  localparam int unsigned CHAN_W = 8;

  // Framer FSM encoding
  typedef logic [0:0] framer_state_t;
  localparam framer_state_t StIdle   = 1'b0;
  localparam framer_state_t StActive = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than 1 bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_video_framer_if.sv
// AXI4-Stream video bundle shared by the framer's input and output sides.
interface axis_video_framer_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry stream buffer with a registered s_ready, so the upstream ready never
// depends combinationally on m_ready. Second entry absorbs the beat in flight.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             s_ready_q;
  logic             push;
  logic             pop;

  assign push = s_valid & s_ready_q;
  assign pop  = (count_q != 2'd0) & m_ready;

  // Occupancy next state; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and registered ready (low whenever the buffer will be full)
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q   <= count_d;
      s_ready_q <= (count_d != 2'd2);
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = (count_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_video_framer.sv
// Video framing stage: tags SOF/EOL from column/row counters, checks upstream
// TLAST against the programmed frame size and buffers through a skid buffer.
module axis_video_framer
  import haze_axis_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned DATA_W     = haze_axis_pkg::DATA_W
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                enable,
  axis_video_framer_if.slave  s_axis,
  axis_video_framer_if.master m_axis,
  output logic                frame_done,
  output logic                err_short,
  output logic                err_long,
  input  logic                err_clr
);

  localparam int unsigned ColW = cnt_w(IMG_WIDTH);
  localparam int unsigned RowW = cnt_w(IMG_HEIGHT);
  // Payload: {rgb, tuser, tlast, frame_end}
  localparam int unsigned PayW = RGB_W + 3;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            err_short_q, err_short_d;
  logic            err_long_q, err_long_d;
  framer_state_t   state_q, state_d;

  logic            skid_s_ready;
  logic [PayW-1:0] pay_in;
  logic [PayW-1:0] pay_out;
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            at_end;
  logic            short_evt;
  logic            long_evt;
  logic            tag_user;
  logic            unused_inputs;

  assign s_axis.tready = enable & skid_s_ready;
  assign accept        = s_axis.tvalid & s_axis.tready;

  assign col_last  = (col_q == ColW'(IMG_WIDTH - 1));
  assign row_last  = (row_q == RowW'(IMG_HEIGHT - 1));
  assign at_end    = col_last & row_last;
  assign tag_user  = (col_q == '0) & (row_q == '0);
  assign short_evt = accept & s_axis.tlast & ~at_end;
  assign long_evt  = accept & ~s_axis.tlast & at_end;

  assign pay_in = {s_axis.tdata[RGB_W-1:0], tag_user, col_last, at_end};

  // Counter advance and frame-size check on every accepted beat
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    if (err_clr) begin
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
    end
    // An error event in the same cycle as err_clr keeps its flag set
    if (short_evt) err_short_d = 1'b1;
    if (long_evt)  err_long_d  = 1'b1;
    if (accept) begin
      if (s_axis.tlast || at_end) begin
        col_d = '0;
        row_d = '0;
      end else if (col_last) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Frame FSM: a frame opens on the first accepted beat, closes on its last
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !(s_axis.tlast || at_end)) state_d = StActive;
      end
      StActive: begin
        if (accept && (s_axis.tlast || at_end)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      col_q       <= '0;
      row_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      state_q     <= StIdle;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      state_q     <= state_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH (PayW)
  ) u_skid (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_valid (s_axis.tvalid & enable),
    .s_data  (pay_in),
    .s_ready (skid_s_ready),
    .m_valid (m_axis.tvalid),
    .m_data  (pay_out),
    .m_ready (m_axis.tready)
  );

  assign m_axis.tdata = {{(DATA_W - RGB_W){1'b0}}, pay_out[PayW-1:3]};
  assign m_axis.tuser = pay_out[2];
  assign m_axis.tlast = pay_out[1];
  assign frame_done   = m_axis.tvalid & m_axis.tready & pay_out[0];

  assign err_short = err_short_q;
  assign err_long  = err_long_q;

  // Alpha byte and upstream TUSER are intentionally ignored
  assign unused_inputs = ^{s_axis.tdata[DATA_W-1:RGB_W], s_axis.tuser};

endmodule
